// File: rtl/udp_payload_packer.sv
// rtl/udp_payload_packer.sv - packs a UDP payload byte stream into 64-bit MSB-first words
// Also checks the sequenced-unit-header length against the real payload length.
module udp_payload_packer #(
  parameter int CNT_W = 16
) (
  input  logic             Clk40,
  input  logic             reset,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [63:0]      out_bytes,
  output logic [7:0]       out_byte_enables,
  output logic             out_data_valid,
  output logic             out_last,
  input  logic             in_ready_for_udp_input,
  output logic [31:0]      pkt_count,
  output logic [CNT_W-1:0] len_err_count,
  output logic             hdr_len_err
);

  localparam int CMP_W = (CNT_W > 16) ? CNT_W : 16;

  logic [63:0]      acc_word;
  logic [7:0]       acc_be;
  logic [3:0]       acc_n;
  logic             acc_done;
  logic             acc_last;
  logic [CNT_W-1:0] pkt_bytes;
  logic [15:0]      hdr_len;

  logic             out_free;
  logic             load;
  logic             accept;

  logic [63:0]      nxt_word;
  logic [7:0]       nxt_be;
  logic [3:0]       nxt_n;
  logic             nxt_done;
  logic             nxt_last;
  logic [CNT_W-1:0] bytes_inc;
  logic [15:0]      hdr_now;
  logic             mismatch;

  assign out_free = !out_data_valid | in_ready_for_udp_input;
  assign load     = acc_done & out_free;
  assign s_ready  = !reset & (!acc_done | out_free);
  assign accept   = s_valid & s_ready;

  // The accumulator empties on a load, so a byte accepted on that same edge lands in lane 0.
  always_comb begin
    nxt_word = load ? 64'h0 : acc_word;
    nxt_be   = load ? 8'h00 : acc_be;
    nxt_n    = load ? 4'd0  : acc_n;
    nxt_done = load ? 1'b0  : acc_done;
    nxt_last = load ? 1'b0  : acc_last;
    if (accept) begin
      for (int k = 0; k < 8; k++) begin
        if (nxt_n == 4'(k)) begin
          nxt_word[63-8*k -: 8] = s_byte;
          nxt_be[7-k]           = 1'b1;
        end
      end
      nxt_done = (nxt_n == 4'd7) | s_last;
      nxt_last = s_last;
      nxt_n    = nxt_n + 4'd1;
    end
  end

  // Length compare includes the byte being accepted, so header bytes still in flight count.
  always_comb begin
    bytes_inc = (pkt_bytes == '1) ? pkt_bytes : pkt_bytes + 1'b1;
    hdr_now   = hdr_len;
    if (pkt_bytes == '0)
      hdr_now = {8'h00, s_byte};
    else if (pkt_bytes == CNT_W'(1))
      hdr_now = {s_byte, hdr_len[7:0]};
    mismatch = CMP_W'(bytes_inc) != CMP_W'(hdr_now);
  end

  always_ff @(posedge Clk40) begin
    if (reset) begin
      acc_word         <= 64'h0;
      acc_be           <= 8'h00;
      acc_n            <= 4'd0;
      acc_done         <= 1'b0;
      acc_last         <= 1'b0;
      out_bytes        <= 64'h0;
      out_byte_enables <= 8'h00;
      out_data_valid   <= 1'b0;
      out_last         <= 1'b0;
      pkt_bytes        <= '0;
      hdr_len          <= 16'h0;
      pkt_count        <= 32'h0;
      len_err_count    <= '0;
      hdr_len_err      <= 1'b0;
    end else begin
      acc_word <= nxt_word;
      acc_be   <= nxt_be;
      acc_n    <= nxt_n;
      acc_done <= nxt_done;
      acc_last <= nxt_last;

      if (load) begin
        out_bytes        <= acc_word;
        out_byte_enables <= acc_be;
        out_last         <= acc_last;
        out_data_valid   <= 1'b1;
      end else if (in_ready_for_udp_input) begin
        out_data_valid   <= 1'b0;
      end

      hdr_len_err <= 1'b0;
      if (accept) begin
        if (s_last) begin
          pkt_bytes <= '0;
          hdr_len   <= 16'h0;
          pkt_count <= pkt_count + 32'd1;
          if (mismatch) begin
            hdr_len_err <= 1'b1;
            if (len_err_count != '1)
              len_err_count <= len_err_count + 1'b1;
          end
        end else begin
          pkt_bytes <= bytes_inc;
          hdr_len   <= hdr_now;
        end
      end
    end
  end

endmodule

// File: doc/udp_payload_packer.md
# udp_payload_packer

Upstream feeder for the BATS PITCH parser. It accepts the UDP payload of each multicast datagram as a byte stream and packs it into 64-bit big-first words with MSB-first byte enables, which is the exact word format the parser consumes on its Bytes / Byte_Enables / data_valid inputs. It honours the parser's Ready_for_Udp_Input backpressure. It also checks the Sequenced Unit Header length field against the actual payload length and keeps packet and error counters.

## Interface
Parameters:
- CNT_W, default 16: width of the per-packet byte counter and of `len_err_count`.

Ports:
- `Clk40`, in, 1: sole clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `s_byte`, in, 8: payload byte.
- `s_valid`, in, 1: `s_byte` is valid.
- `s_last`, in, 1: qualifies the final byte of a datagram.
- `s_ready`, out, 1: byte accepted on an edge where `s_valid & s_ready`.
- `out_bytes`, out, 64: packed word; byte k of the word is in bits [63-8k -: 8].
- `out_byte_enables`, out, 8: bit [7-k] is set when byte k is valid.
- `out_data_valid`, out, 1: word valid; drives the parser's data_valid.
- `out_last`, out, 1: word holds the last byte of the datagram.
- `in_ready_for_udp_input`, in, 1: parser ready.
- `pkt_count`, out, 32: datagrams completed; wraps.
- `len_err_count`, out, CNT_W: header length mismatches; saturates.
- `hdr_len_err`, out, 1: one-cycle pulse on a mismatch.

## Operation
- **Accumulator:** holds `acc_word`, `acc_be`, `acc_n` (0..8) and `acc_done`.
  - An accepted byte is written at lane `acc_n`, its enable bit is set, and `acc_n` increments.
  - `acc_done` is set when `acc_n` reaches 8 or the byte carries `s_last`.
- **Output register:**
  - `out_free = !out_data_valid | in_ready_for_udp_input`.
  - When `acc_done & out_free`, the accumulator is copied to `out_*`, `out_data_valid` is set, and the accumulator clears on the same edge.
  - When `out_data_valid & in_ready_for_udp_input` and no new word loads, `out_data_valid` clears.
  - While `out_data_valid & !in_ready_for_udp_input`, `out_bytes`, `out_byte_enables` and `out_last` hold stable.
- **Ready:** `s_ready = !reset & (!acc_done | out_free)`.
  - When a transfer and a byte acceptance happen on the same edge, the new byte goes to lane 0 of the cleared accumulator.
- **Partial words:** enables are contiguous from the MSB (6 bytes → 8'b11111100). Unused lanes are 0x00.
- **Header check:**
  - Payload bytes 0 and 1 form `hdr_len` = {byte1, byte0}, little-endian.
  - `pkt_bytes` counts accepted bytes of the datagram, including the last one, and saturates at all-ones.
  - On the edge that accepts an `s_last` byte:
    - `pkt_count` increments.
    - If `pkt_bytes != hdr_len`, `hdr_len_err` pulses on the next cycle and `len_err_count` increments.
    - `pkt_bytes` and `hdr_len` clear.
  - A 1-byte datagram uses `hdr_len = {8'h00, byte0}`.
  - The data path forwards mismatched datagrams unchanged.
- **Datagram boundaries:** a word never spans two datagrams. `s_last` always closes the current word.

## Timing
- **Reset values:** `out_bytes`, `out_byte_enables`, `out_last`, `out_data_valid`, `pkt_count`, `len_err_count` and `hdr_len_err` are all 0. The accumulator is empty and `s_ready` = 0 while `reset` is high.
- **Reset mid-datagram:** the partial word, any pending output word, the counters and the header state are all discarded. The next byte after reset is treated as byte 0 of a new datagram.
- **Latency:** the byte completing a word is accepted at edge E. `acc_done` is visible after E. `out_data_valid` rises after edge E+1, provided the output is free at E+1.
- **Throughput:** with the parser continuously ready, 8 bytes produce one word every 8 cycles with no bubble. `s_ready` stays high.
- **Backpressure:**
  - `s_ready` falls only when `acc_done` is set and the output is blocked.
  - At most 16 bytes are buffered (output word plus accumulator).
  - No byte is dropped or duplicated.
- **Simultaneous events:**
  - `s_last` on the 8th lane yields one word with enables 8'hFF and `out_last` = 1. No empty word follows.
  - A consume and a load on the same edge keep `out_data_valid` high.
- **Counters:** `pkt_count` wraps from 0xFFFFFFFF to 0. `len_err_count` holds at all-ones.

## Test plan
- **Time message:**
  - Stimulus: bytes 0e 00 01 01 02 00 00 00 06 20 19 d2 06 00, with `s_last` on byte 14; parser ready.
  - Required: word 64'h0e00010102000000 with enables 8'hFF, then word 64'h062019d206000000 with enables 8'hFC and `out_last` = 1. `pkt_count` = 1, no `hdr_len_err`.
- **Backpressure:**
  - Stimulus: same stream, with `in_ready_for_udp_input` low for 20 cycles starting when the first word appears.
  - Required: the first word stays stable for 20 cycles. `s_ready` drops once the second word completes. Both words then emerge in order, exactly once.
- **Length mismatch:**
  - Stimulus: header 10 00 followed by 12 more bytes (14 total), `s_last` on byte 14.
  - Required: one `hdr_len_err` pulse, `len_err_count` = 1, both words still forwarded.
- **Exact 8-byte datagram:**
  - Stimulus: bytes 08 00 01 01 05 00 00 00 with `s_last` on byte 8.
  - Required: a single word with enables 8'hFF and `out_last` = 1, no extra word, no error.
- **Reset mid-datagram:**
  - Stimulus: 5 bytes accepted, `reset` pulsed for 1 cycle, then the time message.
  - Required: no word emitted from the 5 bytes. The time message output is exactly as in the first scenario. `pkt_count` = 1.
- **Back-to-back datagrams:**
  - Stimulus: two 16-byte datagrams with correct headers, zero gap between them, parser ready.
  - Required: 4 words on consecutive 8-cycle boundaries, `out_last` on words 2 and 4, `s_ready` never low, `pkt_count` = 2.
